// File: rtl/codec_capture_conditioner.sv
// Captures one ADC sample per codec frame (rising edge of New_Frame) into a small FIFO
// with a sticky overflow flag and a combinational head-of-queue output.
module codec_capture_conditioner #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       New_Frame,
  input  logic [WIDTH-1:0]           adc_sample_in,
  input  logic                       sample_ready,
  input  logic                       clear_overflow,
  output logic [WIDTH-1:0]           sample_out,
  output logic                       sample_valid,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             prev_frame_q;

  logic capture, full, pop, push;

  always_comb begin
    capture      = New_Frame && !prev_frame_q;
    full         = (count_q == FullCount);
    sample_valid = (count_q != '0);
    pop          = sample_valid && sample_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    push         = capture && (!full || pop);

    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end

    // Set wins over clear.
    overflow_d = overflow_q;
    if (capture && full && !pop) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      prev_frame_q <= 1'b1;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      prev_frame_q <= New_Frame;
    end
  end

  // Storage is not reset; the count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= adc_sample_in;
    end
  end

  assign sample_out = sample_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_codec_capture_conditioner.sv
// Directed self-checking bench for codec_capture_conditioner (WIDTH=16, DEPTH=4).
module tb_codec_capture_conditioner;

  logic        clk = 1'b0;
  logic        reset;
  logic        New_Frame;
  logic [15:0] adc_sample_in;
  logic        sample_ready;
  logic        clear_overflow;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic [2:0]  fifo_count;
  logic        overflow;

  int pass_cnt = 0;
  int total    = 0;

  codec_capture_conditioner #(.WIDTH(16), .DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .New_Frame     (New_Frame),
    .adc_sample_in (adc_sample_in),
    .sample_ready  (sample_ready),
    .clear_overflow(clear_overflow),
    .sample_out    (sample_out),
    .sample_valid  (sample_valid),
    .fifo_count    (fifo_count),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One capture: New_Frame high for one edge, then low for one edge.
  task automatic frame(input logic [15:0] s);
    adc_sample_in = s;
    New_Frame = 1'b1;
    tick();
    New_Frame = 1'b0;
    tick();
  endtask

  task automatic drain();
    sample_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    sample_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    New_Frame = 1'b0;
    adc_sample_in = '0;
    sample_ready = 1'b0;
    clear_overflow = 1'b0;
    tick();
    tick();
    total++;
    if (fifo_count !== 3'd0 || sample_valid !== 1'b0 || sample_out !== 16'h0 ||
        overflow !== 1'b0) begin
      $display("FAIL reset_state: count=%0d valid=%b out=%h ovf=%b, required 0/0/0000/0",
               fifo_count, sample_valid, sample_out, overflow);
    end else pass_cnt++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    adc_sample_in = 16'h1234;
    New_Frame = 1'b1;
    tick();
    total++;
    if (sample_valid !== 1'b1 || sample_out !== 16'h1234 || fifo_count !== 3'd1) begin
      $display("FAIL single_capture: valid=%b out=%h count=%0d, required 1/1234/1",
               sample_valid, sample_out, fifo_count);
    end else pass_cnt++;
    New_Frame = 1'b0;
    sample_ready = 1'b1;
    tick();
    sample_ready = 1'b0;
    total++;
    if (sample_valid !== 1'b0 || sample_out !== 16'h0 || fifo_count !== 3'd0) begin
      $display("FAIL single_pop: valid=%b out=%h count=%0d, required 0/0000/0",
               sample_valid, sample_out, fifo_count);
    end else pass_cnt++;
  endtask

  task automatic test_long_frame();
    adc_sample_in = 16'h0BEE;
    New_Frame = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    total++;
    if (fifo_count !== 3'd1) begin
      $display("FAIL long_frame_count: count=%0d, required 1", fifo_count);
    end else pass_cnt++;
    New_Frame = 1'b0;
    tick();
    drain();
  endtask

  task automatic test_empty_ready();
    sample_ready = 1'b1;
    tick();
    tick();
    sample_ready = 1'b0;
    total++;
    if (fifo_count !== 3'd0 || sample_valid !== 1'b0) begin
      $display("FAIL ready_while_empty: count=%0d valid=%b, required 0/0",
               fifo_count, sample_valid);
    end else pass_cnt++;
    frame(16'h0077);
    total++;
    if (fifo_count !== 3'd1 || sample_out !== 16'h0077) begin
      $display("FAIL after_empty_ready: count=%0d out=%h, required 1/0077",
               fifo_count, sample_out);
    end else pass_cnt++;
    drain();
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 5; i++) frame(16'(i));
    total++;
    if (fifo_count !== 3'd4 || overflow !== 1'b1) begin
      $display("FAIL overflow_fill: count=%0d ovf=%b, required 4/1", fifo_count, overflow);
    end else pass_cnt++;
    for (int i = 1; i <= 4; i++) begin
      total++;
      if (sample_out !== 16'(i) || sample_valid !== 1'b1) begin
        $display("FAIL overflow_order: out=%h valid=%b, required %h/1",
                 sample_out, sample_valid, 16'(i));
      end else pass_cnt++;
      sample_ready = 1'b1;
      tick();
      sample_ready = 1'b0;
    end
    total++;
    if (sample_valid !== 1'b0 || overflow !== 1'b1) begin
      $display("FAIL overflow_drained: valid=%b ovf=%b, required 0/1 (sticky)",
               sample_valid, overflow);
    end else pass_cnt++;
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    total++;
    if (overflow !== 1'b0) begin
      $display("FAIL overflow_clear: ovf=%b, required 0", overflow);
    end else pass_cnt++;
  endtask

  task automatic test_set_wins();
    for (int i = 0; i < 4; i++) frame(16'h0100 + 16'(i));
    adc_sample_in = 16'hDEAD;
    New_Frame = 1'b1;
    clear_overflow = 1'b1;
    tick();
    New_Frame = 1'b0;
    clear_overflow = 1'b0;
    total++;
    if (overflow !== 1'b1 || fifo_count !== 3'd4 || sample_out !== 16'h0100) begin
      $display("FAIL set_wins: ovf=%b count=%0d out=%h, required 1/4/0100",
               overflow, fifo_count, sample_out);
    end else pass_cnt++;
    tick();
    drain();
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
  endtask

  task automatic test_full_pop();
    logic [15:0] exp_q [4];
    exp_q[0] = 16'h0002; exp_q[1] = 16'h0003; exp_q[2] = 16'h0004; exp_q[3] = 16'hAAAA;
    for (int i = 1; i <= 4; i++) frame(16'(i));
    adc_sample_in = 16'hAAAA;
    New_Frame = 1'b1;
    sample_ready = 1'b1;
    tick();
    New_Frame = 1'b0;
    sample_ready = 1'b0;
    total++;
    if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
      $display("FAIL full_push_pop: count=%0d ovf=%b, required 4/0", fifo_count, overflow);
    end else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (sample_out !== exp_q[i]) begin
        $display("FAIL full_pop_order[%0d]: out=%h, required %h", i, sample_out, exp_q[i]);
      end else pass_cnt++;
      sample_ready = 1'b1;
      tick();
      sample_ready = 1'b0;
    end
    total++;
    if (sample_valid !== 1'b0) begin
      $display("FAIL full_pop_empty: valid=%b, required 0", sample_valid);
    end else pass_cnt++;
  endtask

  task automatic test_stream();
    int max_cnt = 0;
    int bad = 0;
    sample_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      adc_sample_in = 16'hC000 + 16'(i * 7);
      New_Frame = 1'b1;
      tick();
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      total++;
      if (sample_out !== 16'hC000 + 16'(i * 7) || sample_valid !== 1'b1) begin
        $display("FAIL stream_order[%0d]: out=%h valid=%b, required %h/1",
                 i, sample_out, sample_valid, 16'hC000 + 16'(i * 7));
        bad++;
      end else pass_cnt++;
      New_Frame = 1'b0;
      tick();
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    end
    sample_ready = 1'b0;
    total++;
    if (max_cnt != 1 || fifo_count !== 3'd0) begin
      $display("FAIL stream_count: max=%0d final=%0d, required 1/0", max_cnt, fifo_count);
    end else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) frame(16'h5A00 + 16'(i));
    total++;
    if (fifo_count !== 3'd3) begin
      $display("FAIL pre_reset_count: count=%0d, required 3", fifo_count);
    end else pass_cnt++;
    #2;
    reset = 1'b0;
    New_Frame = 1'b1;
    #1;
    total++;
    if (fifo_count !== 3'd0 || sample_out !== 16'h0 || sample_valid !== 1'b0) begin
      $display("FAIL async_reset: count=%0d out=%h valid=%b, required 0/0000/0",
               fifo_count, sample_out, sample_valid);
    end else pass_cnt++;
    tick();
    tick();
    #2;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (fifo_count !== 3'd0 || sample_valid !== 1'b0) begin
      $display("FAIL no_capture_at_release: count=%0d valid=%b, required 0/0",
               fifo_count, sample_valid);
    end else pass_cnt++;
    New_Frame = 1'b0;
    tick();
    adc_sample_in = 16'h9876;
    New_Frame = 1'b1;
    tick();
    total++;
    if (fifo_count !== 3'd1 || sample_out !== 16'h9876) begin
      $display("FAIL capture_after_release: count=%0d out=%h, required 1/9876",
               fifo_count, sample_out);
    end else pass_cnt++;
    New_Frame = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_long_frame();
    test_empty_ready();
    test_overflow();
    test_set_wins();
    test_full_pop();
    test_stream();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
